mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit.
// Multiply uses radix-2 Booth recoding, one multiplier bit per clock.
// Divide uses restoring division on operand magnitudes, one quotient bit per
// clock, followed by a sign-fix cycle. The result register D is loaded only
// on entry to DONE and holds until the next entry to DONE.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    op,
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero,
    output logic [2*DATA_WIDTH-1:0] D
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d;         // latched A (multiplicand / dividend)
    logic [W-1:0]   b_q, b_d;         // latched B (multiplier / divisor)
    logic           op_q, op_d;
    logic           dbz_q, dbz_d;
    logic [W:0]     acc_q, acc_d;     // Booth accumulator / partial remainder
    logic [W-1:0]   lo_q, lo_d;       // Booth multiplier / dividend-quotient
    logic           bit_q, bit_d;     // Booth q(-1) bit
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] d_q, d_d;

    // Datapath helpers
    logic [W-1:0] a_in_abs;
    logic [W-1:0] b_abs;
    logic [W:0]   mcand;
    logic [W:0]   booth_sum;
    logic [W:0]   div_shift;
    logic [W:0]   div_trial;
    logic [W-1:0] rem_mag;
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;

    assign a_in_abs  = A[W-1] ? -A : A;
    assign b_abs     = b_q[W-1] ? -b_q : b_q;
    assign mcand     = {a_q[W-1], a_q};
    assign div_shift = {acc_q[W-1:0], lo_q[W-1]};
    assign div_trial = div_shift - {1'b0, b_abs};
    assign rem_mag   = acc_q[W-1:0];
    assign quo_fix   = (a_q[W-1] ^ b_q[W-1]) ? -lo_q : lo_q;
    assign rem_fix   = a_q[W-1] ? -rem_mag : rem_mag;

    // Booth add/subtract selected by the current multiplier bit pair
    always_comb begin
        booth_sum = acc_q;
        unique case ({lo_q[0], bit_q})
            2'b01:   booth_sum = acc_q + mcand;
            2'b10:   booth_sum = acc_q - mcand;
            default: booth_sum = acc_q;
        endcase
    end

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        // NOTE: every _d defaults to its _q so no path leaves a value unassigned and infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dbz_d   = dbz_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        d_d     = d_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = A;
                    b_d   = B;
                    op_d  = op;
                    dbz_d = op && (B == '0);
                    acc_d = '0;
                    bit_d = 1'b0;
                    cnt_d = '0;
                    lo_d  = op ? a_in_abs : B;
                    // Divide by zero skips the iteration and goes straight to the result cycle
                    state_d = (op && (B == '0)) ? S_SIGN : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SIGN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!op_q) begin
                        // Arithmetic shift right of {acc, lo, bit}
                        acc_d = {booth_sum[W], booth_sum[W:1]};
                        lo_d  = {booth_sum[0], lo_q[W-1:1]};
                        bit_d = lo_q[0];
                    end else if (div_trial[W]) begin
                        // Trial subtraction went negative: restore
                        acc_d = div_shift;
                        lo_d  = {lo_q[W-2:0], 1'b0};
                    end else begin
                        acc_d = div_trial;
                        lo_d  = {lo_q[W-2:0], 1'b1};
                    end
                end
            end
            S_SIGN: begin
                if (dbz_q) begin
                    d_d = {a_q, {W{1'b1}}};
                end else if (op_q) begin
                    d_d = {rem_fix, quo_fix};
                end else begin
                    d_d = {acc_q[W-1:0], lo_q};
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            dbz_q   <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            bit_q   <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dbz_q   <= dbz_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = (state_q == S_DONE) && dbz_q;
    assign D           = d_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a vector table plus random operations,
// a scoreboard queue consumed on each done pulse, and hand-written sequences
// for start-while-busy, mid-operation clear and back-to-back operation.
module tb_mul_div_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] D;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .D           (D)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] d;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [63:0] last_d    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: full signed product, or truncating signed divide
    function automatic logic [63:0] model_d(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
        return p;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_D", D, e.d);
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
            end
        end
    end

    // Issue one operation, optionally poke start while busy, and check latency
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_d, input logic exp_dbz,
                         input int exp_lat, input bit disturb);
        int  n;
        int  guard;
        bit  seen;
        exp_t e;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        e.d   = exp_d;
        e.dbz = exp_dbz;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        // Operand changes after acceptance must not matter
        A  = $urandom;
        B  = $urandom;
        op = ~o;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            if (disturb && n == 9) begin
                start = 1'b1;
                A     = $urandom;
                B     = $urandom;
            end
            @(posedge clock);
            n++;
            #1;
            start = 1'b0;
            if (n == 5) check("D_holds_while_busy", D, last_d);
            @(negedge clock);
            seen = done;
        end
        check("latency", 64'(n), 64'(exp_lat));
        last_d = exp_d;
        @(negedge clock);
        check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        vec_t vecs[10];
        clear = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;

        vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
        vecs[1] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
        vecs[2] = '{1'b0, 32'd0,          32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0};
        vecs[3] = '{1'b1, 32'd17,         32'd5,         64'h0000_0002_0000_0003, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFEF,  32'd5,         64'hFFFF_FFFE_FFFF_FFFD, 1'b0};
        vecs[5] = '{1'b1, 32'd9,          32'd0,         64'h0000_0009_FFFF_FFFF, 1'b1};
        vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0};
        vecs[8] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 1'b0};
        vecs[9] = '{1'b1, 32'd3,          32'd10,        64'h0000_0003_0000_0000, 1'b0};

        // Reset state
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
        check("reset_D",    D, 64'd0);
        @(negedge clock);
        clear = 1'b1;

        // Table vectors, issued back to back; vector 3 also gets a start pulse at k+10
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].dbz,
                  vecs[i].dbz ? 1 : 34, (i == 3));
        end

        // Random operations checked against the model
        for (int i = 0; i < 8; i++) begin
            logic        o;
            logic [31:0] a;
            logic [31:0] b;
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 2) ? 32'd0 : $urandom;
            if (i == 5) b = 32'd1 + 32'($urandom_range(0, 15));
            do_op(o, a, b, model_d(o, a, b), o && (b == 32'd0),
                  (o && (b == 32'd0)) ? 1 : 34, 1'b0);
        end

        // Clear asserted mid-operation: aborts immediately, no done pulse
        check("D_before_abort", D, last_d);
        op    = 1'b0;
        A     = 32'd5;
        B     = 32'd6;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_D",    D, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clock);
        check("abort_D_stays_zero", D, 64'd0);
        clear  = 1'b1;
        last_d = '0;

        // First start after clear release is accepted on the next edge
        do_op(1'b0, 32'd12345, 32'hFFFF_FF00,
              model_d(1'b0, 32'd12345, 32'hFFFF_FF00), 1'b0, 34, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
